// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: capture FSM state encoding
// and, when UART_RXFIFO_TIMEOUT_EN is defined, the baud-derived idle timeout.
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_WAITLOW = 2'd2
    } cap_state_t;

`ifdef UART_RXFIFO_TIMEOUT_EN
    localparam int unsigned SYSCLK_HZ = 100_000_000;
    localparam int unsigned UART_BAUD = 9600;
    // Four bit-times, rounded up to whole sysclk cycles (41667 at 100 MHz / 9600 baud).
    localparam int unsigned RX_TIMEOUT_CYC = (4 * SYSCLK_HZ + UART_BAUD - 1) / UART_BAUD;
`endif

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 register array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
)(
    input  logic          sysclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Storage only; no reset, occupancy tracking lives in the parent.
    always_ff @(posedge sysclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: drains the UART with a one-shot rx_read handshake into a
// DEPTH-entry first-word-fall-through buffer and raises a level irq.
// Optional feature macro: UART_RXFIFO_TIMEOUT_EN (idle timeout folded into irq).
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   ST_IDLE    | waiting for rx_eff
//   ST_ACK     | pulse rx_read, push rx_data (or drop it if full)
//   ST_WAITLOW | byte consumed, waiting for rx_eff to fall
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int THRESH = 1
`ifdef UART_RXFIFO_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = RX_TIMEOUT_CYC
`endif
)(
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_eff,
    output logic        rx_read,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count,
    output logic        overrun,
    input  logic        ovr_clr,
    output logic        irq
);

    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW + 1)'(THRESH);

    cap_state_t    state, state_nxt;
    logic          push_req;
    logic          pop_ok;
    logic          wr_en;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          ovr_q;
    logic          irq_q;
    logic          tmo_flag;
    logic [7:0]    head;

    // Capture FSM state register.
    always_ff @(posedge sysclk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Capture FSM next state: one byte per rx_eff assertion.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (rx_eff) state_nxt = ST_ACK;
            ST_ACK:     state_nxt = ST_WAITLOW;
            ST_WAITLOW: if (!rx_eff) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Capture FSM outputs: ACK both acknowledges the UART and requests a push.
    always_comb begin
        rx_read  = 1'b0;
        push_req = 1'b0;
        if (state == ST_ACK) begin
            rx_read  = 1'b1;
            push_req = 1'b1;
        end
    end

    assign empty  = (cnt == '0);
    assign full   = (cnt == DEPTH_C);
    assign pop_ok = pop & ~empty;
    // A pop on a full FIFO frees the slot for a same-cycle push.
    assign wr_en  = push_req & (~full | pop_ok);

    // Pointers and occupancy.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overrun; a drop in the same cycle as ovr_clr wins.
    always_ff @(posedge sysclk) begin
        if (reset)                           ovr_q <= 1'b0;
        else if (push_req & full & ~pop_ok)  ovr_q <= 1'b1;
        else if (ovr_clr)                    ovr_q <= 1'b0;
    end

`ifdef UART_RXFIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmr;
    logic          idle_low;

    assign idle_low = (cnt != '0) && (cnt < THRESH_C);

    // Idle timeout: reload on any push/pop, count down while below threshold.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tmr      <= '0;
            tmo_flag <= 1'b0;
        end else if (wr_en | pop_ok) begin
            tmr      <= TW'(TIMEOUT_CYC);
            tmo_flag <= 1'b0;
        end else if (idle_low && (tmr != '0)) begin
            tmr <= tmr - 1'b1;
            if (tmr == TW'(1)) tmo_flag <= 1'b1;
        end
    end
`else
    assign tmo_flag = 1'b0;
`endif

    // Registered level interrupt, one cycle behind the occupancy.
    always_ff @(posedge sysclk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (cnt >= THRESH_C) | ovr_q | tmo_flag;
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .sysclk (sysclk),
        .we     (wr_en),
        .waddr  (wr_ptr),
        .wdata  (rx_data),
        .raddr  (rd_ptr),
        .rdata  (head)
    );

    assign rdata   = empty ? 8'h00 : head;
    assign count   = cnt;
    assign overrun = ovr_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor
// compares the head byte on every CPU pop.
module tb_uart_rx_fifo;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_eff  = 1'b0;
    logic       pop     = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       rx_read;
    logic [7:0] rdata;
    logic       empty, full, overrun, irq;
    logic [4:0] count;

    logic [7:0] rx_data2 = 8'h00;
    logic       rx_eff2  = 1'b0;
    logic       pop2     = 1'b0;
    logic       ovr_clr2 = 1'b0;
    logic       rx_read2;
    logic [7:0] rdata2;
    logic       empty2, full2, overrun2, irq2;
    logic [4:0] count2;

    int         passed = 0;
    int         total  = 0;
    int         rd_pulses = 0;
    logic [7:0] exp_q[$];

    always #5 sysclk = ~sysclk;

    uart_rx_fifo #(.DEPTH(16), .AW(4), .THRESH(1)) dut (
        .sysclk (sysclk), .reset (reset), .rx_data (rx_data), .rx_eff (rx_eff),
        .rx_read (rx_read), .pop (pop), .rdata (rdata), .empty (empty),
        .full (full), .count (count), .overrun (overrun), .ovr_clr (ovr_clr),
        .irq (irq)
    );

    uart_rx_fifo #(.DEPTH(16), .AW(4), .THRESH(4)
`ifdef UART_RXFIFO_TIMEOUT_EN
        , .TIMEOUT_CYC(200)
`endif
    ) dut2 (
        .sysclk (sysclk), .reset (reset), .rx_data (rx_data2), .rx_eff (rx_eff2),
        .rx_read (rx_read2), .pop (pop2), .rdata (rdata2), .empty (empty2),
        .full (full2), .count (count2), .overrun (overrun2), .ovr_clr (ovr_clr2),
        .irq (irq2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Monitor: count rx_read pulses and score every CPU pop against the queue.
    always @(negedge sysclk) begin
        if (rx_read) rd_pulses++;
        if (pop && !reset) begin
            if (exp_q.size() > 0) begin
                check("pop_data", {24'h0, rdata}, {24'h0, exp_q[0]});
                void'(exp_q.pop_front());
            end else begin
                check("pop_when_empty_flag", {31'h0, empty}, 32'd1);
            end
        end
    end

    // UART-side byte delivery; caller starts just after a posedge with the FSM idle.
    task automatic send(input logic [7:0] b, input bit keep, input bit with_pop, input bit with_clr);
        if (keep) exp_q.push_back(b);
        rx_data = b;
        rx_eff  = 1'b1;
        @(posedge sysclk); #1;
        check("rx_read_in_ack", {31'h0, rx_read}, 32'd1);
        pop     = with_pop;
        ovr_clr = with_clr;
        @(posedge sysclk); #1;
        pop     = 1'b0;
        ovr_clr = 1'b0;
        rx_eff  = 1'b0;
        @(posedge sysclk); #1;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        @(posedge sysclk); #1;
        pop = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        @(posedge sysclk); #1;

        // Reset state
        check("rst_empty",   {31'h0, empty},   32'd1);
        check("rst_full",    {31'h0, full},    32'd0);
        check("rst_count",   {27'h0, count},   32'd0);
        check("rst_rdata",   {24'h0, rdata},   32'd0);
        check("rst_irq",     {31'h0, irq},     32'd0);
        check("rst_rx_read", {31'h0, rx_read}, 32'd0);
        check("rst_overrun", {31'h0, overrun}, 32'd0);

        // rx_eff held for 5 cycles captures one byte only
        base = rd_pulses;
        exp_q.push_back(8'h55);
        rx_data = 8'h55;
        rx_eff  = 1'b1;
        repeat (5) @(posedge sysclk);
        #1 rx_eff = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        check("one_rx_read_pulse", rd_pulses - base, 32'd1);
        check("hold_count",        {27'h0, count},   32'd1);
        check("hold_rdata",        {24'h0, rdata},   32'h55);
        check("hold_irq",          {31'h0, irq},     32'd1);
        do_pop();
        check("after_pop_count",   {27'h0, count},   32'd0);

        // Fill, overflow, drain with pointer wrap
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
        check("fill_full",  {31'h0, full},  32'd1);
        check("fill_count", {27'h0, count}, 32'd16);
        send(8'hCC, 1'b0, 1'b0, 1'b0);
        check("ovf_overrun", {31'h0, overrun}, 32'd1);
        check("ovf_full",    {31'h0, full},    32'd1);
        check("ovf_rdata",   {24'h0, rdata},   32'h01);
        check("ovf_count",   {27'h0, count},   32'd16);
        check("ovf_irq",     {31'h0, irq},     32'd1);
        repeat (16) do_pop();
        check("drain_empty",   {31'h0, empty},   32'd1);
        check("drain_rdata",   {24'h0, rdata},   32'd0);
        check("sticky_overrun",{31'h0, overrun}, 32'd1);
        ovr_clr = 1'b1;
        @(posedge sysclk); #1;
        ovr_clr = 1'b0;
        check("ovr_clr", {31'h0, overrun}, 32'd0);

        // Full FIFO: pop coincident with ACK keeps the new byte
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
        send(8'hAA, 1'b1, 1'b1, 1'b0);
        check("pp_count",   {27'h0, count},   32'd16);
        check("pp_overrun", {31'h0, overrun}, 32'd0);
        check("pp_rdata",   {24'h0, rdata},   32'h21);
        repeat (16) do_pop();
        check("pp_drained",  {31'h0, empty}, 32'd1);
        check("sb_drained",  exp_q.size(),   32'd0);

        // Pop while empty, then push; set-vs-clear priority
        do_pop();
        check("empty_pop_count", {27'h0, count}, 32'd0);
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        check("after_empty_pop_rdata", {24'h0, rdata}, 32'h3C);
        check("after_empty_pop_count", {27'h0, count}, 32'd1);
        for (int i = 0; i < 15; i++) send(8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
        send(8'hCC, 1'b0, 1'b0, 1'b1);
        check("set_beats_clear", {31'h0, overrun}, 32'd1);
        ovr_clr = 1'b1;
        @(posedge sysclk); #1;
        ovr_clr = 1'b0;
        check("clear_only", {31'h0, overrun}, 32'd0);
        repeat (16) do_pop();
        check("final_empty", {31'h0, empty}, 32'd1);

        // Below-threshold byte on the THRESH=4 instance
        rx_data2 = 8'h77;
        rx_eff2  = 1'b1;
        @(posedge sysclk); #1;
        check("rx_read2", {31'h0, rx_read2}, 32'd1);
        @(posedge sysclk); #1;
        rx_eff2 = 1'b0;
        @(posedge sysclk); #1;
        check("t2_count", {27'h0, count2}, 32'd1);
        check("t2_rdata", {24'h0, rdata2}, 32'h77);
`ifdef UART_RXFIFO_TIMEOUT_EN
        repeat (100) @(posedge sysclk);
        #1;
        check("tmo_early_irq", {31'h0, irq2}, 32'd0);
        repeat (150) @(posedge sysclk);
        #1;
        check("tmo_irq", {31'h0, irq2}, 32'd1);
        pop2 = 1'b1;
        @(posedge sysclk); #1;
        pop2 = 1'b0;
        @(posedge sysclk); #1;
        check("tmo_irq_cleared", {31'h0, irq2}, 32'd0);
`else
        repeat (300) @(posedge sysclk);
        #1;
        check("no_tmo_irq", {31'h0, irq2}, 32'd0);
        pop2 = 1'b1;
        @(posedge sysclk); #1;
        pop2 = 1'b0;
        check("t2_empty", {31'h0, empty2}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
